// File: rtl/gate_bist_pkg.sv
// Shared types, widths and the NAND reference for the gate_bist sequencer.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int VEC_W   = 2;
  localparam int VEC_NUM = 4;
  localparam int CNT_W   = 4;

  function automatic logic nand_expect(input logic [VEC_W-1:0] vec);
    return ~(vec[0] & vec[1]);
  endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Control/result and gate-side signals of the NAND self-test sequencer.
interface gate_bist_if
  import gate_bist_pkg::*;
#(
  parameter int ERR_W = 8
);
  logic               start;
  logic               y_in;
  logic               a_out;
  logic               b_out;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic [VEC_NUM-1:0] fail_vec;

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/bist_settle_timer.sv
// Loadable settle down-counter; zero_next flags that the pending decrement reaches zero.
module bist_settle_timer
  import gate_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count register: load has priority, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero_next = (count_r == CNT_ONE) || (count_r == CNT_ZERO);

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer: walks a 2-input NAND through its truth table LOOPS times and scores Y.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 4,
  parameter int ERR_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  gate_bist_if.slave  bus
);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [7:0]         LOOP_LAST = 8'(LOOPS - 1);
  localparam logic [VEC_W-1:0]   VEC_ZERO  = {VEC_W{1'b0}};
  localparam logic [VEC_W-1:0]   VEC_ONE   = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0]   VEC_LAST  = {VEC_W{1'b1}};
  localparam logic [ERR_W-1:0]   ERR_ZERO  = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]   ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]   ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [VEC_NUM-1:0] FAIL_ZERO = {VEC_NUM{1'b0}};

  state_e             state_r, state_s;
  logic [VEC_W-1:0]   vec_r, vec_s;
  logic [7:0]         loop_r, loop_s;
  logic [ERR_W-1:0]   err_r, err_s;
  logic [VEC_NUM-1:0] fail_r, fail_s;
  logic               pass_r, pass_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               a_r, a_s;
  logic               b_r, b_s;
  logic               tmr_load_s, tmr_dec_s, tmr_zero_s;

  bist_settle_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load_s),
    .load_val  (SETTLE_LD),
    .dec       (tmr_dec_s),
    .zero_next (tmr_zero_s)
  );

  // Next-state, counters and results; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_s    = state_r;
    vec_s      = vec_r;
    loop_s     = loop_r;
    err_s      = err_r;
    fail_s     = fail_r;
    pass_s     = pass_r;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_APPLY;
          vec_s   = VEC_ZERO;
          loop_s  = 8'd0;
          err_s   = ERR_ZERO;
          fail_s  = FAIL_ZERO;
          pass_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        tmr_load_s = 1'b1;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_dec_s = 1'b1;
        if (tmr_zero_s) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        if (bus.y_in != nand_expect(vec_r)) begin
          fail_s[vec_r] = 1'b1;
          if (err_r != ERR_MAX) begin
            err_s = err_r + ERR_ONE;
          end else begin
            err_s = err_r;
          end
        end else begin
          err_s = err_r;
        end
        if (vec_r != VEC_LAST) begin
          vec_s   = vec_r + VEC_ONE;
          state_s = ST_APPLY;
        end else if (loop_r != LOOP_LAST) begin
          loop_s  = loop_r + 8'd1;
          vec_s   = VEC_ZERO;
          state_s = ST_APPLY;
        end else begin
          // pass must already be valid in the done cycle
          pass_s  = (err_s == ERR_ZERO);
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_APPLY) || (state_s == ST_WAIT) || (state_s == ST_SAMPLE);
    done_s = (state_s == ST_DONE);
    a_s    = busy_s & vec_s[0];
    b_s    = busy_s & vec_s[1];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      vec_r   <= VEC_ZERO;
      loop_r  <= 8'd0;
      err_r   <= ERR_ZERO;
      fail_r  <= FAIL_ZERO;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_r     <= 1'b0;
      b_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      loop_r  <= loop_s;
      err_r   <= err_s;
      fail_r  <= fail_s;
      pass_r  <= pass_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      a_r     <= a_s;
      b_r     <= b_s;
    end
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_r;
  assign bus.fail_vec  = fail_r;

endmodule

// File: tb/tb_gate_bist.sv
// Randomised self-checking bench for gate_bist with a cycle-indexed behavioural model of a run.
module tb_gate_bist;
  localparam int S       = 2;
  localparam int L       = 4;
  localparam int EW      = 3;
  localparam int T       = L * 4 * (S + 2);
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic flip = 1'b0;
  int   mode = 0;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  gate_bist_if #(.ERR_W(EW)) bus ();

  gate_bist #(.SETTLE_CYCLES(S), .LOOPS(L), .ERR_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // mode 0: good NAND, 1: stuck-at-1, 2: AND, 3: good NAND with random output flips
  function automatic logic gate_y(input int md, input logic a, input logic b);
    case (md)
      1:       return 1'b1;
      2:       return a & b;
      default: return ~(a & b);
    endcase
  endfunction

  assign bus.y_in = gate_y(mode, bus.a_out, bus.b_out) ^ flip;

  always @(negedge clk) flip <= (mode == 3) && ($urandom_range(0, 3) == 0);

  // Model: m_n is the index of the current cycle within a run (0 idle, 1..T running, T+1 done).
  int         m_n = 0;
  int         m_err = 0;
  logic [3:0] m_fail = 4'b0000;
  logic       m_pass = 1'b0;

  function automatic int vec_of(input int n);
    return ((n - 1) / (S + 2)) % 4;
  endfunction

  function automatic bit is_sample(input int n);
    return ((n - 1) % (S + 2)) == (S + 1);
  endfunction

  function automatic bit miss_at(input int n, input int md, input logic fl);
    int   v = vec_of(n);
    logic a = v[0];
    logic b = v[1];
    return (gate_y(md, a, b) ^ fl) != ~(a & b);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_n    <= 0;
      m_err  <= 0;
      m_fail <= 4'b0000;
      m_pass <= 1'b0;
    end else if (m_n == 0) begin
      if (bus.start) begin
        m_n    <= 1;
        m_err  <= 0;
        m_fail <= 4'b0000;
        m_pass <= 1'b0;
      end
    end else if (m_n <= T) begin
      if (is_sample(m_n) && miss_at(m_n, mode, flip)) begin
        m_err <= (m_err < ERR_MAX) ? m_err + 1 : m_err;
        m_fail[vec_of(m_n)] <= 1'b1;
      end
      if (m_n == T) m_pass <= (m_err == 0) && !miss_at(m_n, mode, flip);
      m_n <= m_n + 1;
    end else begin
      m_n <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", bus.busy, (m_n >= 1 && m_n <= T));
        check("done", bus.done, (m_n == T + 1));
        check("a_out", bus.a_out, (m_n >= 1 && m_n <= T) ? (vec_of(m_n) & 1) : 0);
        check("b_out", bus.b_out, (m_n >= 1 && m_n <= T) ? ((vec_of(m_n) >> 1) & 1) : 0);
        check("err_count", bus.err_count, m_err);
        check("fail_vec", bus.fail_vec, m_fail);
        check("pass", bus.pass, m_pass);
      end
    end
  end

  task automatic run_once(input int md, output int lat);
    mode = md;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= T + 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int cnt;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.busy, bus.done, bus.pass, bus.a_out, bus.b_out, bus.err_count, bus.fail_vec}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // done is visible in the cycle after edge t0 + 4*4*(2+2)
    run_once(0, lat);
    check("nand_latency", lat, 32'd65);
    check("nand_pass", bus.pass, 32'd1);
    check("nand_err", bus.err_count, 32'd0);
    check("nand_fail", bus.fail_vec, 32'b0000);

    run_once(1, lat);
    check("stuck1_latency", lat, 32'd65);
    check("stuck1_err", bus.err_count, 32'd4);
    check("stuck1_fail", bus.fail_vec, 32'b1000);
    check("stuck1_pass", bus.pass, 32'd0);

    // 16 mismatches saturate a 3-bit counter
    run_once(2, lat);
    check("and_err_sat", bus.err_count, 32'd7);
    check("and_fail", bus.fail_vec, 32'b1111);
    check("and_pass", bus.pass, 32'd0);

    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_once(3, lat);
      check("rand_latency", lat, 32'd65);
    end

    // start pulse mid-run is ignored; start held through DONE launches a fresh run
    mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (56) @(negedge clk);
    bus.start = 1'b1;
    lat = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = j;
        break;
      end
    end
    check("held_done_at", lat, 32'd2);
    check("held_err_first", bus.err_count, 32'd4);
    @(negedge clk);
    check("held_idle_busy", bus.busy, 32'd0);
    check("held_idle_err", bus.err_count, 32'd4);
    @(negedge clk);
    check("held_restart_busy", bus.busy, 32'd1);
    check("held_restart_err", bus.err_count, 32'd0);
    check("held_restart_pass", bus.pass, 32'd0);
    bus.start = 1'b0;
    cnt = 0;
    for (int j = 0; j < T + 10; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    check("held_second_done", cnt, 32'd1);

    // abort during WAIT of vector 2
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_vec2_b", bus.b_out, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {bus.busy, bus.done, bus.pass, bus.a_out, bus.b_out, bus.err_count, bus.fail_vec}, 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int j = 0; j < T + 20; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    check("abort_no_done", cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_bist.md
# gate_bist

Built-in self-test sequencer for a 2-input NAND cell. It drives the cell's A/B inputs through the full truth table, waits a programmable settle time, samples the cell's Y output and checks it against the expected NAND value. It sits beside the gate in the user design: its outputs feed the gate inputs and the gate output returns to it. Error count, failing-vector mask and a pass flag go to spare `uo_out` bits.

## Interface
- `SETTLE_CYCLES`, default 2: wait cycles between applying a vector and sampling Y; legal range 1..15.
- `LOOPS`, default 4: number of complete 4-vector passes per run; legal range 1..255.
- `ERR_W`, default 8: error counter width.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level, sampled only in IDLE; begins a run.
- `y_in` in 1: output of the gate under test.
- `a_out` out 1: gate input A; equals vector index bit 0.
- `b_out` out 1: gate input B; equals vector index bit 1.
- `busy` out 1: high from the cycle after start is accepted until DONE.
- `done` out 1: one-cycle pulse when a run completes.
- `pass` out 1: high after a run with zero errors; held until the next start.
- `err_count` out ERR_W: mismatches in the current or last run; saturating.
- `fail_vec` out 4: sticky per-vector mismatch mask; bit i set when vector i ever failed in the run.

## Operation
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE:
  - a_out = b_out = 0, busy = 0.
  - start = 1 → APPLY, with vector = 0, loop = 0, err_count = 0, fail_vec = 0, pass = 0.
- APPLY: drive the current vector (order 00, 01, 10, 11 as {b,a}) and load the settle counter with SETTLE_CYCLES → WAIT.
- WAIT: decrement the counter each cycle; when it reaches 0 → SAMPLE.
- SAMPLE: compare y_in with ~(a_out & b_out).
  - On mismatch: err_count increments, saturating at 2^ERR_W−1; fail_vec[vector] is set.
  - Vector < 3: vector increments → APPLY.
  - Vector = 3 and loop < LOOPS−1: loop increments, vector = 0 → APPLY.
  - Otherwise → DONE.
- DONE: done = 1, busy = 0, pass = (err_count == 0) → IDLE.
- a_out and b_out hold the vector through APPLY, WAIT and SAMPLE, so the gate input is stable at the sample point.
- start while busy is ignored, including in DONE. If start is still high in IDLE, a new run begins and clears the results.
- rst at any time: next state IDLE, all outputs 0, counters cleared. An aborted run reports nothing.

## Timing
- Start is accepted at edge t0; busy rises and vector 0 appears on a_out/b_out after t0.
- Each vector takes 1 + SETTLE_CYCLES + 1 cycles (APPLY, WAIT, SAMPLE).
- done pulses in the cycle after edge t0 + LOOPS·4·(SETTLE_CYCLES+2).
- pass and err_count are final in the done cycle and stable after it.
- y_in is sampled SETTLE_CYCLES+1 cycles after the vector changes.
- y_in is assumed synchronous to clk (the gate is on-chip and combinational); no synchroniser.
- Reset value of every output: 0.

## Structure
- Shared package `gate_bist_pkg`:
  - state enum.
  - vector width (2) and vector count (4).
  - function `nand_expect(vec)` returning ~(vec[0] & vec[1]).
  - settle counter width (4).
- One natural sub-module, `bist_settle_timer`: loadable down-counter with a zero flag. The FSM, vector/loop counters and result registers stay in `gate_bist`.

## Test plan
- Correct NAND model, SETTLE=2, LOOPS=1, start pulse at t0 → done at cycle t0+16, pass = 1, err_count = 0, fail_vec = 0000.
- Gate output stuck at 1, LOOPS=4 → vector 3 fails every loop: err_count = 4, fail_vec = 1000, pass = 0.
- AND in place of NAND, LOOPS=2 → err_count = 8, fail_vec = 1111, pass = 0.
- ERR_W=2, AND gate, LOOPS=4 → err_count saturates at 3, fail_vec = 1111.
- start pulsed at vector 1, then held high through DONE:
  - pulse ignored; single done.
  - second run begins the cycle after DONE, clearing err_count/pass.
- rst asserted while vector 2 is in WAIT → next cycle: busy, done, pass, a_out, b_out, err_count, fail_vec all 0; no done pulse follows.
